// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters, per-requester burst credit, registered one-hot grant.
// Optional macro ARB_LOCK_EN adds a `lock` input that holds the current grant past its credit.
module wrr_arbiter #(
  parameter  int N  = 4,
  parameter  int CW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] weight,
`ifdef ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_valid
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] ptr_r, ptr_s;        // last owner; equals the current owner while BUSY
  logic [CW-1:0] credit_r, credit_s;
  logic          found_s;
  logic [IW-1:0] pick_s;
  logic [CW-1:0] wsel_s, load_s;
  logic          hold_s, hit_s;
  logic [N-1:0]  grant_s;
  int            cand_s;

  // Round-robin search starting after ptr; the current owner comes last
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = 0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s  = int'(ptr_r) + k;
      cand_s  = (cand_s >= N) ? cand_s - N : cand_s;
      hit_s   = req[cand_s] && !found_s;
      pick_s  = hit_s ? IW'(cand_s) : pick_s;
      found_s = found_s | hit_s;
    end
    wsel_s = weight[int'(pick_s)*CW +: CW];
    load_s = (wsel_s == '0) ? CW'(1) : wsel_s;
  end

  // Burst continuation and next-state selection
  always_comb begin
`ifdef ARB_LOCK_EN
    hold_s = req[ptr_r] && ((credit_r > CW'(1)) || lock);
`else
    hold_s = req[ptr_r] && (credit_r > CW'(1));
`endif
    state_s  = state_r;
    ptr_s    = ptr_r;
    credit_s = credit_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s  = BUSY;
          ptr_s    = pick_s;
          credit_s = load_s;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (hold_s) begin
          // under lock the credit parks at 1 instead of wrapping
          credit_s = (credit_r > CW'(1)) ? credit_r - CW'(1) : credit_r;
        end else if (found_s) begin
          ptr_s    = pick_s;
          credit_s = load_s;
        end else begin
          state_s  = IDLE;
          credit_s = '0;
        end
      end
      default: begin
        state_s  = IDLE;
        credit_s = '0;
      end
    endcase
  end

  // One-hot decode of the next owner
  always_comb begin
    grant_s = '0;
    for (int i = 0; i < N; i++) begin
      grant_s[i] = (state_s == BUSY) && (ptr_s == IW'(i));
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      ptr_r       <= IW'(N-1);
      credit_r    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      credit_r    <= credit_s;
      grant       <= grant_s;
      grant_idx   <= (state_s == BUSY) ? ptr_s : '0;
      grant_valid <= (state_s == BUSY);
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter (N=4, CW=4): directed scenarios plus random traffic
// compared against a burst/rotation reference model.
module tb_wrr_arbiter;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*CW-1:0] weight;
  logic            lock;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_valid;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model: owner (-1 when idle), rotation pointer, grants left in burst
  int m_owner = -1;
  int m_ptr   = N-1;
  int m_left  = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .weight(weight),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int burst_of(input int i);
    int w;
    w = int'(weight[i*CW +: CW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_edge();
    bit lk;
    int nxt;
`ifdef ARB_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    if (!rst) begin
      m_owner = -1; m_ptr = N-1; m_left = 0;
    end else if (m_owner >= 0 && req[m_owner] && (m_left > 1 || lk)) begin
      if (m_left > 1) m_left--;
    end else begin
      nxt = -1;
      for (int k = 1; k <= N; k++)
        if (nxt < 0 && req[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
      if (nxt >= 0) begin
        m_owner = nxt; m_ptr = nxt; m_left = burst_of(nxt);
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_value("model_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check_value("model_idx",   32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_value("model_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] exp_g, input string tag);
    req = r;
    tick();
    check_value(tag, 32'(grant), 32'(exp_g));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [N-1:0] rr_exp [8]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [N-1:0] wt_exp [12] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h4,
                                4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h4};

  initial begin
    rst = 1'b0; req = 4'b1111; weight = 16'h1111; lock = 1'b0;

    // reset with everyone requesting
    tick();
    tick();
    check_value("rst_grant", 32'(grant), 32'd0);
    check_value("rst_valid", 32'(grant_valid), 32'd0);
    check_value("rst_idx",   32'(grant_idx), 32'd0);
    rst = 1'b1;

    // plain round robin
    for (int i = 0; i < 8; i++) step(4'b1111, rr_exp[i], "plain_rr");

    // weighted 3/2/1
    do_reset();
    weight = 16'h1123;
    for (int i = 0; i < 12; i++) step(4'b0111, wt_exp[i], "weighted");

    // early release by owner
    do_reset();
    weight = 16'h1114;
    step(4'b0011, 4'b0001, "early_g0a");
    step(4'b0011, 4'b0001, "early_g0b");
    step(4'b0010, 4'b0010, "early_rel");
    check_value("early_idx", 32'(grant_idx), 32'd1);

    // sole requester with weight 0, then idle and pointer retention
    do_reset();
    weight = 16'h0111;
    for (int i = 0; i < 5; i++) step(4'b1000, 4'b1000, "sole_w0");
    step(4'b0000, 4'b0000, "sole_idle");
    step(4'b1001, 4'b0001, "ptr_kept");

`ifdef ARB_LOCK_EN
    do_reset();
    weight = 16'h1111;
    step(4'b0011, 4'b0001, "lock_pre0");
    step(4'b0011, 4'b0010, "lock_pre1");
    lock = 1'b1;
    for (int i = 0; i < 5; i++) step(4'b0011, 4'b0010, "lock_hold");
    lock = 1'b0;
    step(4'b0011, 4'b0001, "lock_rel");
`endif

    // random traffic, weight changes and occasional reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req = 4'b1111;
      if ($urandom_range(0, 9) == 0) weight = 16'($urandom);
      lock = 1'($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 59) != 0);
      tick();
      check_value("onehot", 32'($countones(grant) <= 1), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter for N requesters. It generalises the team's fixed 4-way round-robin arbiter: width is configurable, each requester has a per-requester weight (burst credit), and the grant is held for up to `weight` consecutive cycles. The output is a registered one-hot grant plus encoded index. It sits in front of shared resources such as a bus, memory port or output queue.

Parameters:
N, 4, number of requesters (2..32)
CW, 4, width of each weight field; weight 0 is treated as 1
IW, $clog2(N), width of grant_idx (derived localparam, not overridable)

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  synchronous, active-low reset
req  input  N  request vector, bit i = requester i
weight  input  N*CW  packed weights, field i = weight[i*CW +: CW]
grant  output  N  registered one-hot grant, 0 when idle
grant_idx  output  IW  index of granted requester; 0 when idle
grant_valid  output  1  high when grant is nonzero
lock  input  1  present only with ARB_LOCK_EN (see Optional Feature)

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-low. While rst=0 at a rising edge:
  - grant=0, grant_idx=0, grant_valid=0.
  - Credit counter = 0.
  - Last-owner pointer ptr = N-1, so index 0 has top priority after reset.
- Latency: req is sampled at a rising edge. The grant reflecting it is visible after that same edge, i.e. one registered stage.
- State machine:
  - IDLE (grant=0).
  - BUSY (grant=one-hot of owner, credit = grants remaining in the burst, including the current cycle).
- IDLE behaviour:
  - If req==0, stay in IDLE.
  - Otherwise grant the first requesting index, searching ptr+1, ptr+2, ... with wrap modulo N.
  - Set owner = that index and ptr = owner.
  - Load credit = weight[owner], or 1 if that weight is 0. Go to BUSY.
- BUSY behaviour, evaluated every edge:
  - a) req[owner]=1 and credit>1: keep grant, credit-=1.
  - b) Otherwise (owner dropped req, or credit==1): re-arbitrate from ptr+1 with wrap.
    - The owner itself is eligible, but last in priority order.
    - A sole requester whose credit is exhausted is re-granted back-to-back with its credit reloaded. No idle bubble.
  - c) If no request is pending in case b: grant=0, go to IDLE. ptr is retained.
- Weights are sampled only when a grant is loaded. A change mid-burst takes effect on the next grant to that requester.
- Owner drop: if req[owner] falls, the grant is released at the next edge. Unused credit is discarded.
- The grant never switches to a requester whose req bit is 0 at the sampling edge.
- grant is always one-hot or zero. grant_idx and grant_valid are registered alongside grant and are consistent with it every cycle.
- Fairness: with all N requesting continuously, each requester i receives exactly max(weight[i],1) grants per rotation, in index order.
- Reset mid-burst: outputs clear at that edge. Credits and the owner are lost; the next arbitration starts from index 0.
- N not a power of 2: wrap is modulo N. grant_idx never exceeds N-1.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input `lock` (1 bit).
  - While in BUSY with lock=1 and req[owner]=1, the grant is held regardless of credit. Credit stays at 1 rather than underflowing.
  - When lock falls, normal credit rules resume; credit==1 causes re-arbitration at the next edge.
  - lock has no effect in IDLE or when req[owner]=0.
- Undefined: no `lock` port; pure weighted round-robin as above.

Test Plan (N=4, CW=4):
- Reset: rst=0 for 2 edges with req=1111 -> grant=0000, grant_valid=0, grant_idx=0. Release with req=1111 and all weights 1 -> first grant 0001.
- Plain round-robin: all weights 1, req=1111 for 8 cycles -> grant 0001,0010,0100,1000,0001,0010,0100,1000.
- Weighted: weight={w3..w0}={1,1,2,3}, req=0111 -> 0001×3, 0010×2, 0100×1, then repeat.
- Early release: w0=4, req=0011; drop req[0] after its 2nd grant cycle -> next cycle grant=0010, grant_idx=1.
- Sole requester and weight 0: req=1000, w3=0 -> grant=1000 every cycle with no gap. Then req=0000 -> grant=0000, and ptr is retained: req=1001 next -> 0001 granted first.
- Lock (ARB_LOCK_EN): w1=1, req=0011, lock=1 after grant=0010 -> 0010 held for 5 cycles. Lock falls -> next grant 0001.
